// File: rtl/dvi_timing_gen_if.sv
// Pixel request / pixel return / timing output bundle of the DVI timing generator.
// The generator side uses the master modport; the pixel source and TFP410 stage use slave.
interface dvi_timing_gen_if;
    logic        pix_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [7:0]  pixel_r_in;
    logic [7:0]  pixel_g_in;
    logic [7:0]  pixel_b_in;
    logic        vsync_o;
    logic        hsync_o;
    logic        de_o;
    logic [7:0]  pixel_r_o;
    logic [7:0]  pixel_g_o;
    logic [7:0]  pixel_b_o;
    logic        frame_start;

    modport master (
        output pix_req, pix_x, pix_y,
        output vsync_o, hsync_o, de_o,
        output pixel_r_o, pixel_g_o, pixel_b_o,
        output frame_start,
        input  pixel_r_in, pixel_g_in, pixel_b_in
    );

    modport slave (
        input  pix_req, pix_x, pix_y,
        input  vsync_o, hsync_o, de_o,
        input  pixel_r_o, pixel_g_o, pixel_b_o,
        input  frame_start,
        output pixel_r_in, pixel_g_in, pixel_b_in
    );
endinterface

// File: rtl/dvi_timing_gen.sv
// DVI raster timing generator: h/v counters, pixel requests, 3-stage aligned sync/DE/RGB.
// Optional macro TEST_PATTERN_EN replaces the pixel source with 8 vertical colour bars.
module dvi_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input logic              odck_in,
    input logic              rst,
    dvi_timing_gen_if.master dvi
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] HActEnd  = 12'(H_ACTIVE);
    localparam logic [11:0] HSyncBeg = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HSyncEnd = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] HLast    = 12'(H_TOTAL - 1);
    localparam logic [11:0] VActEnd  = 12'(V_ACTIVE);
    localparam logic [11:0] VSyncBeg = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VSyncEnd = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] VLast    = 12'(V_TOTAL - 1);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        h_wrap;
    logic        de_raw, hs_raw, vs_raw;
    logic        req;
    logic [11:0] px;
    logic [2:0]  de_pipe_q, de_pipe_d;
    logic [2:0]  hs_pipe_q, hs_pipe_d;
    logic [2:0]  vs_pipe_q, vs_pipe_d;
    logic [23:0] src_rgb;
    logic [23:0] rgb_q, rgb_d;
`ifdef TEST_PATTERN_EN
    logic [2:0]  bar1_q, bar1_d;
    logic [2:0]  bar2_q, bar2_d;
`endif

    always_comb begin
        h_wrap  = (h_cnt_q == HLast);
        h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == VLast) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    // vsync depends on v_cnt only, so it can only move on a line boundary.
    always_comb begin
        de_raw = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
        hs_raw = (h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd);
        vs_raw = (v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd);
        req    = de_raw & ~rst;
        px     = req ? h_cnt_q : 12'd0;
    end

`ifdef TEST_PATTERN_EN
    // Bar index follows the request by two cycles, matching external source latency.
    always_comb begin
        bar1_d  = px[9:7];
        bar2_d  = bar1_q;
        src_rgb = {{8{~bar2_q[1]}}, {8{~bar2_q[2]}}, {8{~bar2_q[0]}}};
    end
`else
    always_comb begin
        src_rgb = {dvi.pixel_r_in, dvi.pixel_g_in, dvi.pixel_b_in};
    end
`endif

    // Stage 1 of each pipe holds the raw value of the previous cycle; stage 2 lines up
    // with the returned pixel data, which is captured into the output register.
    always_comb begin
        de_pipe_d = {de_pipe_q[1:0], de_raw};
        hs_pipe_d = {hs_pipe_q[1:0], hs_raw};
        vs_pipe_d = {vs_pipe_q[1:0], vs_raw};
        rgb_d     = de_pipe_q[1] ? src_rgb : 24'd0;
    end

    always_ff @(posedge odck_in) begin
        if (rst) begin
            h_cnt_q   <= 12'd0;
            v_cnt_q   <= 12'd0;
            de_pipe_q <= 3'd0;
            hs_pipe_q <= 3'd0;
            vs_pipe_q <= 3'd0;
            rgb_q     <= 24'd0;
`ifdef TEST_PATTERN_EN
            bar1_q    <= 3'd0;
            bar2_q    <= 3'd0;
`endif
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            de_pipe_q <= de_pipe_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            rgb_q     <= rgb_d;
`ifdef TEST_PATTERN_EN
            bar1_q    <= bar1_d;
            bar2_q    <= bar2_d;
`endif
        end
    end

    // Request and frame_start are gated by rst so they stay low during the reset cycles.
    always_comb begin
        dvi.pix_req     = req;
        dvi.pix_x       = px;
        dvi.pix_y       = req ? v_cnt_q : 12'd0;
        dvi.frame_start = ~rst && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        dvi.de_o        = de_pipe_q[2];
        dvi.hsync_o     = hs_pipe_q[2] ? HS_POL : ~HS_POL;
        dvi.vsync_o     = vs_pipe_q[2] ? VS_POL : ~VS_POL;
        dvi.pixel_r_o   = rgb_q[23:16];
        dvi.pixel_g_o   = rgb_q[15:8];
        dvi.pixel_b_o   = rgb_q[7:0];
    end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen: reduced frame height, full 1344-pixel line,
// per-cycle reference check, hand-computed edge points, per-frame totals and reset aborts.
module tb_dvi_timing_gen;

    localparam int HA  = 1024;
    localparam int HFP = 24;
    localparam int HSW = 136;
    localparam int HBP = 160;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VSW = 3;
    localparam int VBP = 2;
    localparam int HT  = 1344;
    localparam int VT  = 15;
    localparam int FT  = 20160;

    localparam logic [63:0] RstVec = {11'd0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'd0};

    typedef struct packed {
        int          t;
        int          sel;
        logic [23:0] val;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dvi_timing_gen_if dvi ();

    dvi_timing_gen #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HSW),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSW),
        .V_BP     (VBP),
        .HS_POL   (1'b0),
        .VS_POL   (1'b0)
    ) dut (
        .odck_in (clk),
        .rst     (rst),
        .dvi     (dvi)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   t        = 0;
    vec_t vecs[$];

    logic        req1 = 1'b0, req2 = 1'b0;
    logic [11:0] x1 = 12'd0, x2 = 12'd0;

    int   de_cnt, hs_low, hs_falls, vs_low, vs_falls, vs_fall_t;
    logic prev_hs, prev_vs;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_vec(input int vt, input int sel, input logic [23:0] val);
        vec_t v;
        v.t   = vt;
        v.sel = sel;
        v.val = val;
        vecs.push_back(v);
    endtask

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Reference outputs for cycle tt after reset release, from the raster definition.
    function automatic logic [63:0] exp_vec(input int tt);
        int          h, v, u, hp, vp;
        logic        rq, de, hs, vs, fs;
        logic [11:0] px, py;
        logic [23:0] rgb;
        logic [7:0]  lo;
        h   = tt % HT;
        v   = (tt / HT) % VT;
        rq  = (h < HA) && (v < VA);
        px  = rq ? 12'(h) : 12'd0;
        py  = rq ? 12'(v) : 12'd0;
        fs  = (tt % FT) == 0;
        de  = 1'b0;
        hs  = 1'b0;
        vs  = 1'b0;
        rgb = 24'd0;
        if (tt >= 3) begin
            u  = tt - 3;
            hp = u % HT;
            vp = (u / HT) % VT;
            de = (hp < HA) && (vp < VA);
            hs = (hp >= HA + HFP) && (hp < HA + HFP + HSW);
            vs = (vp >= VA + VFP) && (vp < VA + VFP + VSW);
            lo = 8'(hp);
            if (de) begin
`ifdef TEST_PATTERN_EN
                rgb = bar_rgb(hp / 128);
`else
                rgb = {lo, ~lo, 8'h5A};
`endif
            end
        end
        return {11'd0, rq, px, py, fs, de, ~hs, ~vs, rgb};
    endfunction

    function automatic logic [63:0] obs_vec();
        return {11'd0, dvi.pix_req, dvi.pix_x, dvi.pix_y, dvi.frame_start, dvi.de_o,
                dvi.hsync_o, dvi.vsync_o, dvi.pixel_r_o, dvi.pixel_g_o, dvi.pixel_b_o};
    endfunction

    function automatic logic [23:0] sel_obs(input int sel);
        case (sel)
            0:       return {23'd0, dvi.de_o};
            1:       return {23'd0, dvi.hsync_o};
            2:       return {23'd0, dvi.vsync_o};
            3:       return {dvi.pixel_r_o, dvi.pixel_g_o, dvi.pixel_b_o};
            4:       return {23'd0, dvi.frame_start};
            default: return {23'd0, dvi.pix_req};
        endcase
    endfunction

    // Pixel source: answers a request two cycles later, drives junk when nothing was asked.
    task automatic src_step();
`ifdef TEST_PATTERN_EN
        dvi.pixel_r_in = 8'h55;
        dvi.pixel_g_in = 8'h55;
        dvi.pixel_b_in = 8'h55;
`else
        if (req2) begin
            dvi.pixel_r_in = x2[7:0];
            dvi.pixel_g_in = ~x2[7:0];
            dvi.pixel_b_in = 8'h5A;
        end else begin
            dvi.pixel_r_in = 8'hA5;
            dvi.pixel_g_in = 8'hA5;
            dvi.pixel_b_in = 8'hA5;
        end
`endif
        req2 = req1;
        x2   = x1;
        req1 = dvi.pix_req;
        x1   = dvi.pix_x;
    endtask

    task automatic cycle_checks();
        check_eq($sformatf("cycle t=%0d", t), obs_vec(), exp_vec(t));
        foreach (vecs[i]) begin
            if (vecs[i].t == t) begin
                check_eq($sformatf("point sel=%0d t=%0d", vecs[i].sel, t),
                         {40'd0, sel_obs(vecs[i].sel)}, {40'd0, vecs[i].val});
            end
        end
        if (t == 3) begin
            de_cnt = 0; hs_low = 0; hs_falls = 0; vs_low = 0; vs_falls = 0; vs_fall_t = -1;
            prev_hs = 1'b1;
            prev_vs = 1'b1;
        end
        if (t == FT + 3) begin
            check_eq("frame de cycles", 64'(de_cnt), 64'd8192);
            check_eq("frame hsync low cycles", 64'(hs_low), 64'd2040);
            check_eq("frame hsync pulses", 64'(hs_falls), 64'd15);
            check_eq("frame vsync low cycles", 64'(vs_low), 64'd4032);
            check_eq("frame vsync pulses", 64'(vs_falls), 64'd1);
            check_eq("vsync start", 64'(vs_fall_t), 64'd13443);
        end
        if (t >= 3 && t < FT + 3) begin
            de_cnt += int'(dvi.de_o);
            hs_low += int'(!dvi.hsync_o);
            vs_low += int'(!dvi.vsync_o);
            if (prev_hs && !dvi.hsync_o) hs_falls++;
            if (prev_vs && !dvi.vsync_o) begin
                vs_falls++;
                vs_fall_t = t;
            end
            prev_hs = dvi.hsync_o;
            prev_vs = dvi.vsync_o;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            t++;
            src_step();
            cycle_checks();
        end
    endtask

    task automatic release_rst();
        rst = 1'b0;
        #1;
        t = 0;
        src_step();
        cycle_checks();
    endtask

    // One-cycle reset pulse starting in the current cycle.
    task automatic abort_frame(input string tag);
        rst = 1'b1;
        tick();
        check_eq(tag, obs_vec(), RstVec);
        release_rst();
    endtask

    initial begin
        add_vec(0, 4, 24'd1);
        add_vec(1, 4, 24'd0);
        add_vec(2, 0, 24'd0);
        add_vec(3, 0, 24'd1);
        add_vec(1023, 5, 24'd1);
        add_vec(1024, 5, 24'd0);
        add_vec(1026, 0, 24'd1);
        add_vec(1027, 0, 24'd0);
        add_vec(1050, 1, 24'd1);
        add_vec(1051, 1, 24'd0);
        add_vec(1186, 1, 24'd0);
        add_vec(1187, 1, 24'd1);
        add_vec(1346, 0, 24'd0);
        add_vec(1347, 0, 24'd1);
        add_vec(13442, 2, 24'd1);
        add_vec(13443, 2, 24'd0);
        add_vec(17474, 2, 24'd0);
        add_vec(17475, 2, 24'd1);
        add_vec(20160, 4, 24'd1);
`ifdef TEST_PATTERN_EN
        add_vec(3, 3, 24'hFFFFFF);
        add_vec(130, 3, 24'hFFFFFF);
        add_vec(131, 3, 24'hFFFF00);
        add_vec(898, 3, 24'h0000FF);
        add_vec(1026, 3, 24'h000000);
`else
        add_vec(3, 3, 24'h00FF5A);
        add_vec(4, 3, 24'h01FE5A);
        add_vec(258, 3, 24'hFF005A);
        add_vec(259, 3, 24'h00FF5A);
        add_vec(1027, 3, 24'h000000);
`endif
        dvi.pixel_r_in = 8'h00;
        dvi.pixel_g_in = 8'h00;
        dvi.pixel_b_in = 8'h00;

        rst = 1'b1;
        repeat (5) begin
            tick();
            src_step();
            check_eq("reset values", obs_vec(), RstVec);
        end
        release_rst();

        // Abort inside vsync and hsync of the second frame, then inside active video.
        run(FT + 11 * HT + 1100);
        abort_frame("abort in sync");
        run(4 * HT + 500);
        abort_frame("abort in active");
        run(FT + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvi_timing_gen.md
DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 1024, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 24 / 136 / 160, horizontal front porch, sync width and back porch in pixels.
REQ-003 Parameter V_ACTIVE, 768, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 3 / 6 / 29, vertical porches and sync width in lines.
REQ-005 Parameter HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low).
REQ-006 Port odck_in, input, 1, pixel clock; the only clock in the block.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port pix_req, output, 1, high when the generator is requesting the pixel at pix_x / pix_y.
REQ-009 Port pix_x / pix_y, output, 12 each, coordinate of the requested pixel; 0 when pix_req is low.
REQ-010 Port pixel_r_in / pixel_g_in / pixel_b_in, input, 8 each, pixel data returned by the source exactly 2 cycles after the pix_req cycle.
REQ-011 Port vsync_o / hsync_o / de_o, output, 1 each, timing outputs aligned with pixel data; these drive the TFP410 stage's vsync_in / hsync_in / de_in.
REQ-012 Port pixel_r_o / pixel_g_o / pixel_b_o, output, 8 each, registered pixel data.
REQ-013 Port frame_start, output, 1, one-cycle pulse when the counters are at h=0, v=0 (undelayed).

Function
REQ-014 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP) and wrap to 0; counters are 12 bits and H_TOTAL, V_TOTAL ≤ 4095.
REQ-015 v_cnt SHALL increment only on the cycle h_cnt wraps, and SHALL itself wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-016 pix_req SHALL be high iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; when it is high, pix_x=h_cnt and pix_y=v_cnt.
REQ-017 Raw hsync SHALL be active iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-018 Raw vsync SHALL be active iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, changing only on line boundaries (h_cnt=0).
REQ-019 Raw de, hsync and vsync SHALL pass through a 3-stage register pipeline, so de_o / hsync_o / vsync_o appear 3 cycles after the counter state.
REQ-020 pixel_*_in SHALL be registered on the cycle 2 cycles after pix_req, so pixel data and de_o leave the block on the same cycle.
REQ-021 pixel_*_o SHALL be 0 whenever de_o is 0, regardless of pixel_*_in.
REQ-022 Each sync output SHALL equal *_POL when active and ~*_POL when inactive.
REQ-023 Per frame: exactly V_ACTIVE×H_ACTIVE de_o cycles, V_TOTAL hsync pulses and one vsync pulse of V_SYNC×H_TOTAL cycles.

Reset
REQ-024 While rst=1 on a clock edge: h_cnt=v_cnt=0, all pipeline stages cleared, de_o=0, pix_req=0, pix_x=pix_y=0, pixel_*_o=0, frame_start=0, hsync_o=~HS_POL, vsync_o=~VS_POL.
REQ-025 On the first cycle after rst falls, the counters SHALL be at h=0, v=0 and frame_start SHALL be 1.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately, with no partial sync pulse after rst is released.

Configuration
REQ-027 When TEST_PATTERN_EN is defined, pixel_*_in SHALL be ignored and the block SHALL output 8 vertical colour bars.
- Bar index = pix_x[9:7], delayed by 2 cycles.
- Order: white, yellow, cyan, green, magenta, red, blue, black; components are 0xFF or 0x00.
- pix_req still toggles as in REQ-016.
REQ-028 When TEST_PATTERN_EN is undefined, pixel data SHALL come from pixel_*_in as in REQ-020.

Verification
REQ-029 Hold rst 5 cycles, then release -> during reset hsync_o=vsync_o=1, de_o=0, RGB=0; frame_start=1 on the first cycle after release.
REQ-030 Free-run one line -> de_o high for 1024 cycles starting 3 cycles after h=0; hsync_o low for 136 cycles starting at de rise+1048; line period 1344.
REQ-031 Source returns RGB=pix_x[7:0] 2 cycles after pix_req -> pixel_r_o sequence 0,1,2,…,255,0 during de_o; 0 outside de.
REQ-032 Run two frames -> frame period 1,083,264 cycles; vsync_o low for 8064 cycles, starting 771 lines after frame_start+3.
REQ-033 Assert rst at line 400, pixel 500, for 1 cycle -> next cycle outputs are at reset values; the following frame timing is identical to REQ-030/032.
REQ-034 Build with TEST_PATTERN_EN -> pixel_*_in held at 0x55; line 0 outputs FFFFFF for 128 de cycles, then FFFF00, and ends with 000000.
